prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 29 ++
 rtl/prog_loader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the processor core:
// writeback status codes, loader FSM encoding and the default load address.
package prog_loader_pkg;

  // Writeback-stage status codes
  localparam logic [1:0] STAT_INS = 2'b00;
  localparam logic [1:0] STAT_AOK = 2'b01;
  localparam logic [1:0] STAT_HLT = 2'b10;
  localparam logic [1:0] STAT_ADR = 2'b11;

  // Default program placement and memory size
  localparam logic [63:0] LOAD_BASE_DEFAULT = 64'd64;
  localparam int unsigned MEM_BYTES_DEFAULT = 32'd1024;

  // Loader / run-control state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  // Running modulo-256 checksum step
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams bytes into memory starting at LOAD_BASE, validates
// the trailing checksum, then enables the processor and tracks its run status.
import prog_loader_pkg::*;

module prog_loader #(
  parameter logic [63:0] LOAD_BASE = LOAD_BASE_DEFAULT,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [1:0]  W_stat,
  output logic        cpu_run,
  output logic [63:0] boot_pc,
  output logic        load_err,
  output logic        halted,
  output logic [1:0]  final_stat,
  output logic [31:0] cycle_count
);

  state_e      state_q, state_d;
  logic [63:0] index_q, index_d;
  logic [7:0]  csum_q, csum_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        halted_q, halted_d;
  logic [1:0]  final_stat_q, final_stat_d;
  logic [31:0] cycle_count_q, cycle_count_d;

  logic        accept;
  logic [63:0] wr_addr;
  logic        mem_full;
  logic [7:0]  csum_next;

  // The byte stream is open only before the program has been committed.
  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept    = in_valid && in_ready;
  assign wr_addr   = LOAD_BASE + index_q;
  // ">=" also covers a LOAD_BASE placed beyond the end of memory.
  assign mem_full  = (wr_addr >= 64'(MEM_BYTES));
  assign csum_next = csum_add(csum_q, in_data);

  assign cpu_run     = (state_q == ST_RUN);
  assign load_err    = (state_q == ST_ERR);
  assign boot_pc     = LOAD_BASE;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign halted      = halted_q;
  assign final_stat  = final_stat_q;
  assign cycle_count = cycle_count_q;

  // Next-state logic: loading, checksum verdict, run monitoring, terminal states.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    csum_d        = csum_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    halted_d      = halted_q;
    final_stat_d  = final_stat_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          if (mem_full) begin
            // Program does not fit: drop the byte and fail the load.
            state_d = ST_ERR;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = in_data;
            index_d     = index_q + 64'd1;
            csum_d      = csum_next;
            if (in_last) begin
              state_d = (csum_next == 8'd0) ? ST_RUN : ST_ERR;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_RUN: begin
        if (W_stat == STAT_AOK) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end else begin
          final_stat_d = W_stat;
          halted_d     = 1'b1;
          state_d      = ST_HALTED;
        end
      end

      ST_HALTED, ST_ERR: begin
        state_d = state_q;
      end

      default: begin
        // Illegal encoding: park in the failure state.
        state_d = ST_ERR;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      index_q       <= 64'd0;
      csum_q        <= 8'd0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 64'd0;
      mem_wdata_q   <= 8'd0;
      halted_q      <= 1'b0;
      final_stat_q  <= STAT_AOK;
      cycle_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      csum_q        <= csum_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      halted_q      <= halted_d;
      final_stat_q  <= final_stat_d;
      cycle_count_q <= cycle_count_d;
    end
  end

endmodule
